// File: rtl/rv_regfile_mp_pkg.sv
// rtl/rv_regfile_mp_pkg.sv - shared widths, register address type and zero-register constant
package rv_regfile_mp_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int NRD_DEF   = 2;
   localparam int REG_AW    = $clog2(NREGS_DEF);

   typedef logic [REG_AW-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/rv_regfile_mp_if.sv
// rtl/rv_regfile_mp_if.sv - read, writeback and issue-scoreboard bus of the multi-port register file
interface rv_regfile_mp_if
   import rv_regfile_mp_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = NRD_DEF
) ();
   localparam int AW = $clog2(NREGS);

   logic [NRD-1:0]      rd_en;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_valid;
   logic [NRD-1:0]      rd_busy;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                sb_set_en;
   logic [AW-1:0]       sb_set_addr;
   logic [NREGS-1:0]    busy_vec;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
      input  rd_data, rd_valid, rd_busy, busy_vec
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
      output rd_data, rd_valid, rd_busy, busy_vec
   );
endinterface

// File: rtl/rv_regfile_mp_scoreboard.sv
// rtl/rv_regfile_mp_scoreboard.sv - pending-write busy bits with set-over-clear priority
module rv_scoreboard
   import rv_regfile_mp_pkg::*;
#(
   parameter int NREGS = NREGS_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_set_en,
   input  logic [$clog2(NREGS)-1:0] i_set_addr,
   input  logic                     i_clr_en,
   input  logic [$clog2(NREGS)-1:0] i_clr_addr,
   output logic [NREGS-1:0]         o_busy_vec
);
   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;

   // Clear from writeback first, then set from issue so a new producer overrides the retiring one
   always_comb begin
      w_busy_nxt = r_busy;
      if (i_clr_en) begin
         w_busy_nxt[i_clr_addr] = 1'b0;
      end
      if (i_set_en) begin
         w_busy_nxt[i_set_addr] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Busy bit register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign o_busy_vec = r_busy;
endmodule

// File: rtl/rv_regfile_mp.sv
// rtl/rv_regfile_mp.sv - multi-read-port register file with pending-write scoreboard (option: REGFILE_BYPASS_EN)
module rv_regfile_mp
   import rv_regfile_mp_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = NRD_DEF
) (
   input  logic           i_clk,
   input  logic           i_rst,
   rv_regfile_mp_if.slave io_bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]          r_regs [NREGS];
   logic [NRD-1:0][XLEN-1:0] r_rd_data;
   logic [NRD-1:0]           r_rd_valid;
   logic [NRD-1:0]           r_rd_busy;

   logic [NREGS-1:0]         w_busy_vec;
   logic [NRD-1:0][AW-1:0]   w_rd_addr;
   logic [NRD-1:0][XLEN-1:0] w_rd_data_nxt;
   logic [NRD-1:0]           w_rd_busy_nxt;
   logic                     w_wr_hit;

   assign w_rd_addr = io_bus.rd_addr;
   assign w_wr_hit  = io_bus.wr_en && (io_bus.wr_addr != AW'(REG_ZERO));

   rv_scoreboard #(
      .NREGS (NREGS)
   ) u_scoreboard (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_set_en   (io_bus.sb_set_en),
      .i_set_addr (io_bus.sb_set_addr),
      .i_clr_en   (io_bus.wr_en),
      .i_clr_addr (io_bus.wr_addr),
      .o_busy_vec (w_busy_vec)
   );

   // Storage array; register 0 is never written so it stays at its reset value of zero
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_hit) begin
         r_regs[io_bus.wr_addr] <= io_bus.wr_data;
      end
   end

   // Per-port read mux: zero register, optional same-cycle writeback forwarding, else stored value
   always_comb begin
      w_rd_data_nxt = '0;
      w_rd_busy_nxt = '0;
      for (int p = 0; p < NRD; p++) begin
         if (w_rd_addr[p] == AW'(REG_ZERO)) begin
            w_rd_data_nxt[p] = '0;
            w_rd_busy_nxt[p] = 1'b0;
         end
`ifdef REGFILE_BYPASS_EN
         else if (io_bus.wr_en && (io_bus.wr_addr == w_rd_addr[p])) begin
            w_rd_data_nxt[p] = io_bus.wr_data;
            w_rd_busy_nxt[p] = io_bus.sb_set_en && (io_bus.sb_set_addr == w_rd_addr[p]);
         end
`endif
         else begin
            w_rd_data_nxt[p] = r_regs[w_rd_addr[p]];
            w_rd_busy_nxt[p] = w_busy_vec[w_rd_addr[p]];
         end
      end
   end

   // Read pipeline; idle ports keep their last data and busy flag
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= '0;
         r_rd_busy  <= '0;
      end else begin
         r_rd_valid <= io_bus.rd_en;
         for (int p = 0; p < NRD; p++) begin
            if (io_bus.rd_en[p]) begin
               r_rd_data[p] <= w_rd_data_nxt[p];
               r_rd_busy[p] <= w_rd_busy_nxt[p];
            end
         end
      end
   end

   assign io_bus.rd_data  = r_rd_data;
   assign io_bus.rd_valid = r_rd_valid;
   assign io_bus.rd_busy  = r_rd_busy;
   assign io_bus.busy_vec = w_busy_vec;
endmodule

// File: tb/tb_rv_regfile_mp.sv
// tb/tb_rv_regfile_mp.sv - scoreboard bench for rv_regfile_mp with a reference model of the register file
module tb_rv_regfile_mp;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 4;
   localparam int AW    = 5;

   typedef struct {
      logic            v;
      logic [XLEN-1:0] d;
      logic            b;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rv_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

   rv_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   exp_t             exp_q [NRD][$];
   logic [NREGS-1:0] busy_q[$];

   logic [XLEN-1:0]  m_regs [NREGS];
   logic             m_busy [NREGS];
   logic [XLEN-1:0]  m_last_d [NRD];
   logic             m_last_b [NRD];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   task automatic idle();
      bus.rd_en       = '0;
      bus.rd_addr     = '0;
      bus.wr_en       = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
      bus.sb_set_en   = 1'b0;
      bus.sb_set_addr = '0;
   endtask

   task automatic rd(input int p, input int a);
      bus.rd_en[p]              = 1'b1;
      bus.rd_addr[p*AW +: AW]   = AW'(a);
   endtask

   task automatic wr(input int a, input logic [XLEN-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = d;
   endtask

   task automatic sb(input int a);
      bus.sb_set_en   = 1'b1;
      bus.sb_set_addr = AW'(a);
   endtask

   // Predict the outcome of the inputs now on the bus, update the model, then clock once
   task automatic do_cycle();
      exp_t             e;
      int               a;
      logic [NREGS-1:0] bv;
      for (int p = 0; p < NRD; p++) begin
         a = int'(bus.rd_addr[p*AW +: AW]);
         if (rst) begin
            m_last_d[p] = '0;
            m_last_b[p] = 1'b0;
            e = '{v: 1'b0, d: '0, b: 1'b0};
         end else if (!bus.rd_en[p]) begin
            e = '{v: 1'b0, d: m_last_d[p], b: m_last_b[p]};
         end else begin
            if (a == 0) begin
               m_last_d[p] = '0;
               m_last_b[p] = 1'b0;
            end else begin
               m_last_d[p] = m_regs[a];
               m_last_b[p] = m_busy[a];
`ifdef REGFILE_BYPASS_EN
               if (bus.wr_en && int'(bus.wr_addr) == a) begin
                  m_last_d[p] = bus.wr_data;
                  m_last_b[p] = bus.sb_set_en && int'(bus.sb_set_addr) == a;
               end
`endif
            end
            e = '{v: 1'b1, d: m_last_d[p], b: m_last_b[p]};
         end
         exp_q[p].push_back(e);
      end
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (bus.wr_en && bus.wr_addr != 0) m_regs[bus.wr_addr] = bus.wr_data;
         if (bus.wr_en) m_busy[bus.wr_addr] = 1'b0;
         if (bus.sb_set_en && bus.sb_set_addr != 0) m_busy[bus.sb_set_addr] = 1'b1;
      end
      for (int i = 0; i < NREGS; i++) bv[i] = m_busy[i];
      busy_q.push_back(bv);
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int rand_addr();
      if ($urandom_range(3) == 0) return int'($urandom_range(NREGS-1));
      return int'($urandom_range(7));
   endfunction

   exp_t             mon_e;
   logic [NREGS-1:0] mon_bv;

   // Monitor: after every edge pop one expectation per port plus the scoreboard vector
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int p = 0; p < NRD; p++) begin
            if (exp_q[p].size() > 0) begin
               mon_e = exp_q[p].pop_front();
               check($sformatf("rd_valid[%0d]", p), XLEN'(bus.rd_valid[p]), XLEN'(mon_e.v));
               check($sformatf("rd_data[%0d]", p), bus.rd_data[p*XLEN +: XLEN], mon_e.d);
               check($sformatf("rd_busy[%0d]", p), XLEN'(bus.rd_busy[p]), XLEN'(mon_e.b));
            end
         end
         if (busy_q.size() > 0) begin
            mon_bv = busy_q.pop_front();
            check("busy_vec", XLEN'(bus.busy_vec), XLEN'(mon_bv));
         end
      end
   end

   initial begin
      rst = 1'b1;
      idle();
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      for (int p = 0; p < NRD; p++) begin
         m_last_d[p] = '0;
         m_last_b[p] = 1'b0;
      end
      @(negedge clk);
      do_cycle();
      do_cycle();
      rst = 1'b0;

      // Reset discards earlier writes
      idle(); wr(5, 32'hDEAD); do_cycle();
      idle(); rst = 1'b1; rd(0, 5); wr(6, 32'h1); sb(6); do_cycle();
      rst = 1'b0;
      idle(); rd(0, 5); do_cycle();

      // Basic dual-port read of the same register
      idle(); wr(3, 32'h1234_5678); do_cycle();
      idle(); rd(0, 3); rd(1, 3); do_cycle();

      // Register 0 ignores writes and issue marks
      idle(); wr(0, 32'hFFFF_FFFF); sb(0); do_cycle();
      idle(); rd(0, 0); rd(1, 0); rd(2, 0); rd(3, 0); do_cycle();

      // Same-cycle write and read of r7
      idle(); wr(7, 32'h11); do_cycle();
      idle(); sb(7); do_cycle();
      idle(); wr(7, 32'hA5A5_A5A5); rd(0, 7); rd(1, 7); do_cycle();
      idle(); rd(0, 7); do_cycle();

      // Scoreboard set, set-beats-clear, then clear
      idle(); sb(9); do_cycle();
      idle(); wr(9, 32'h99); sb(9); rd(0, 9); do_cycle();
      idle(); wr(9, 32'h98); rd(1, 9); do_cycle();
      idle(); rd(2, 9); sb(9); do_cycle();
      idle(); sb(9); rd(3, 9); do_cycle();

      // Four ports in one cycle
      idle(); wr(1, 32'hAAAA_0001); do_cycle();
      idle(); wr(2, 32'hBBBB_0002); do_cycle();
      idle(); rd(0, 1); rd(1, 2); rd(2, 3); rd(3, 0); do_cycle();
      idle(); rd(2, 1); do_cycle();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         idle();
         rst = ($urandom_range(63) == 0);
         for (int p = 0; p < NRD; p++) begin
            if ($urandom_range(1) == 1) rd(p, rand_addr());
            else bus.rd_addr[p*AW +: AW] = AW'(rand_addr());
         end
         if ($urandom_range(1) == 1) wr(rand_addr(), $urandom);
         if ($urandom_range(9) < 3) sb(rand_addr());
         do_cycle();
      end
      rst = 1'b0;
      idle();
      do_cycle();
      do_cycle();

      @(posedge clk);
      #2;
      check("exp_q drained", XLEN'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), '0);
      check("busy_q drained", XLEN'(busy_q.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
